// File: rtl/lab8_soc_gpio_port.sv
// lab8_soc_gpio_port
// Avalon-MM slave GPIO port for the lab8 SoC. It provides a per-bit output
// register with atomic set/clear, a per-bit direction register, synchronised
// inputs, and edge capture that drives a maskable level interrupt to the Nios II.
//
// Register map (word index on address):
//   0 DATA    rd: per bit, direction ? data_out : in_sync   wr: data_out <= wd
//   1 DIR     rd/wr direction (1 = output)
//   2 MASK    rd/wr irq_mask
//   3 EDGE    rd edge_cap; wr clears the bits where wd = 1
//   4 OUTSET  wr data_out |= wd; reads 0
//   5 OUTCLR  wr data_out &= ~wd; reads 0
//   6,7       reads 0; writes ignored
module lab8_soc_gpio_port #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  // The arming counter saturates once the synchroniser and the prev flop
  // both hold real pin samples rather than reset zeros.
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic                              wr;
  logic [WIDTH-1:0]                  wd;
  logic [WIDTH-1:0]                  data_out;
  logic [WIDTH-1:0]                  direction;
  logic [WIDTH-1:0]                  irq_mask;
  logic [WIDTH-1:0]                  edge_cap;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  in_sync;
  logic [WIDTH-1:0]                  in_prev;
  logic [2:0]                        arm_cnt;
  logic                              armed;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  edge_evt;
  logic [WIDTH-1:0]                  edge_clr;
  logic [WIDTH-1:0]                  read_val;
  logic                              unused_writedata;

  assign wr      = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign in_sync = sync_q[SYNC_STAGES-1];
  assign armed   = (arm_cnt == ARM_MAX);

  // Bits of writedata above WIDTH carry no meaning for this port.
  assign unused_writedata = ^writedata;

  // Output data register: plain write, atomic set and atomic clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_out <= wd;
        ADDR_OUTSET: data_out <= data_out | wd;
        ADDR_OUTCLR: data_out <= data_out & ~wd;
        default:     data_out <= data_out;
      endcase
    end
  end

  // Direction and interrupt mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      direction <= DIR_RESET;
      irq_mask  <= '0;
    end else if (wr) begin
      if (address == ADDR_DIR) begin
        direction <= wd;
      end
      if (address == ADDR_MASK) begin
        irq_mask <= wd;
      end
    end
  end

  // Input synchroniser chain followed by one extra flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      in_prev <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pio_in};
      in_prev <= in_sync;
    end
  end

  // Arming counter keeps edge detection off while the pipeline fills after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 3'd1;
    end
  end

  // Select which transitions count as events, gated by the arming state.
  always_comb begin
    rise     = in_sync & ~in_prev;
    fall     = ~in_sync & in_prev;
    edge_evt = '0;
    if (armed) begin
      case (EDGE_TYPE)
        0:       edge_evt = rise;
        1:       edge_evt = fall;
        default: edge_evt = rise | fall;
      endcase
    end
  end

  // Write-one-to-clear mask for the capture register.
  always_comb begin
    edge_clr = '0;
    if (wr && (address == ADDR_EDGE)) begin
      edge_clr = wd;
    end
  end

  // Edge capture: a new event on the same edge as a clear keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~edge_clr) | edge_evt;
    end
  end

  // Zero-latency read mux; chipselect intentionally does not gate it.
  always_comb begin
    read_val = '0;
    case (address)
      ADDR_DATA: read_val = (direction & data_out) | (~direction & in_sync);
      ADDR_DIR:  read_val = direction;
      ADDR_MASK: read_val = irq_mask;
      ADDR_EDGE: read_val = edge_cap;
      default:   read_val = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = read_val;
  end

  assign out_port = data_out;
  assign out_oe   = direction;
  assign irq      = |(edge_cap & irq_mask);

endmodule
